// File: rtl/neocore_pkg.sv
// Shared writeback types: load-queue entry layout, default queue depth, saturating counter helper.
package neocore_pkg;

  localparam int LQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic        valid;
    logic        dead;
    logic [3:0]  rd;
    logic [15:0] data;
  } wb_entry_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/wb_load_queue.sv
// Circular load-response queue with per-entry squash against same-cycle pipe destinations.
// WB_PERF_CNT_EN adds a newly-squashed entry count output.
module wb_load_queue
  import neocore_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  wb_entry_t                 i_push_entry,
  input  logic [1:0]                i_pop_cnt,
  input  logic [1:0]                i_sq_vld,
  input  logic [1:0][3:0]           i_sq_rd,
  output wb_entry_t                 o_head0,
  output wb_entry_t                 o_head1,
  output logic [$clog2(LQ_DEPTH):0] o_count,
  output logic                      o_ready
`ifdef WB_PERF_CNT_EN
  ,
  output logic [$clog2(LQ_DEPTH):0] o_new_dead
`endif
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);

  wb_entry_t         r_q [LQ_DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic              r_ready;

  logic [PW-1:0]       w_head1_idx;
  logic [LQ_DEPTH-1:0] w_hit, w_pop;
  logic [CW-1:0]       w_count_nxt;

  assign w_head1_idx = r_head + PW'(1);

  // Squash is applied combinationally so an entry granted this very cycle already sees it.
  for (genvar i = 0; i < LQ_DEPTH; i++) begin : g_ent
    assign w_hit[i] = r_q[i].valid &
                      ((i_sq_vld[0] && (r_q[i].rd == i_sq_rd[0])) ||
                       (i_sq_vld[1] && (r_q[i].rd == i_sq_rd[1])));
    assign w_pop[i] = ((i_pop_cnt != 2'd0) && (r_head == PW'(i))) ||
                      ((i_pop_cnt == 2'd2) && (w_head1_idx == PW'(i)));
  end

  always_comb begin
    o_head0      = r_q[r_head];
    o_head0.dead = r_q[r_head].dead | w_hit[r_head];
    o_head1      = r_q[w_head1_idx];
    o_head1.dead = r_q[w_head1_idx].dead | w_hit[w_head1_idx];
  end

`ifdef WB_PERF_CNT_EN
  always_comb begin
    o_new_dead = '0;
    for (int i = 0; i < LQ_DEPTH; i++)
      o_new_dead = o_new_dead + CW'(w_hit[i] & ~r_q[i].dead);
  end
`endif

  assign w_count_nxt = r_count + CW'(i_push) - CW'(i_pop_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LQ_DEPTH; i++) r_q[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        if (w_pop[i])      r_q[i].valid <= 1'b0;
        else if (w_hit[i]) r_q[i].dead  <= 1'b1;
      end
      // Push only happens with a free slot, so the tail never aliases a popped entry.
      if (i_push) begin
        r_q[r_tail] <= i_push_entry;
        r_tail      <= r_tail + PW'(1);
      end
      r_head  <= r_head + PW'(i_pop_cnt);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < DEPTH_C);
    end
  end

  assign o_count = r_count;
  assign o_ready = r_ready;

endmodule

// File: rtl/writeback_unit.sv
// Two-port register-file writeback: pipes own their ports, loads fill free ports via bypass or queue.
// WB_PERF_CNT_EN adds saturating load-stall and squash counters.
module writeback_unit
  import neocore_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      p0_valid,
  input  logic [3:0]                p0_rd,
  input  logic [15:0]               p0_data,
  input  logic                      p1_valid,
  input  logic [3:0]                p1_rd,
  input  logic [15:0]               p1_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [3:0]                ld_rd,
  input  logic [15:0]               ld_data,
  output logic [3:0]                rd_addr_0,
  output logic [3:0]                rd_addr_1,
  output logic [15:0]               rd_data_0,
  output logic [15:0]               rd_data_1,
  output logic                      rd_we_0,
  output logic                      rd_we_1,
  output logic [$clog2(LQ_DEPTH):0] lq_count
`ifdef WB_PERF_CNT_EN
  ,
  output logic [15:0]               perf_ld_stall,
  output logic [15:0]               perf_squash
`endif
);

  logic        r_we0, r_we1;
  logic [3:0]  r_addr0, r_addr1;
  logic [15:0] r_data0, r_data1;

  logic        w_we0, w_we1;
  logic [3:0]  w_addr0, w_addr1;
  logic [15:0] w_data0, w_data1;
  logic [1:0]  w_grant, w_pop_cnt;
  logic        w_ld_acc, w_ld_dead, w_qempty, w_push;
  wb_entry_t   w_head0, w_head1, w_ld_ent, w_c0, w_c1;

  assign w_ld_acc  = ld_valid & ld_ready;
  assign w_ld_dead = (p0_valid && (p0_rd == ld_rd)) || (p1_valid && (p1_rd == ld_rd));
  assign w_qempty  = (lq_count == '0);

  always_comb begin
    w_ld_ent       = '0;
    w_ld_ent.valid = 1'b1;
    w_ld_ent.dead  = w_ld_dead;
    w_ld_ent.rd    = ld_rd;
    w_ld_ent.data  = ld_data;
  end

  // Candidates oldest-first: queue head, next entry; the incoming load only bypasses an empty queue.
  always_comb begin
    w_c0 = '0;
    w_c1 = '0;
    if (!w_qempty) begin
      w_c0       = w_head0;
      w_c0.valid = w_head0.valid;
      if (lq_count > 1) w_c1 = w_head1;
    end else if (w_ld_acc) begin
      w_c0 = w_ld_ent;
    end
  end

  always_comb begin
    w_we0 = 1'b0; w_addr0 = '0; w_data0 = '0;
    w_we1 = 1'b0; w_addr1 = '0; w_data1 = '0;
    w_grant = 2'd0;
    if (p0_valid) begin
      w_we0 = 1'b1; w_addr0 = p0_rd; w_data0 = p0_data;
    end else if (w_c0.valid) begin
      w_we0 = ~w_c0.dead; w_addr0 = w_c0.rd; w_data0 = w_c0.data;
      w_grant = 2'd1;
    end
    if (p1_valid) begin
      w_we1 = 1'b1; w_addr1 = p1_rd; w_data1 = p1_data;
    end else if (p0_valid) begin
      if (w_c0.valid) begin
        w_we1 = ~w_c0.dead; w_addr1 = w_c0.rd; w_data1 = w_c0.data;
        w_grant = 2'd1;
      end
    end else if (w_c1.valid) begin
      // Older entry already on port 0; younger lands on port 1 which wins in the register file.
      w_we1 = ~w_c1.dead; w_addr1 = w_c1.rd; w_data1 = w_c1.data;
      w_grant = 2'd2;
    end
  end

  assign w_pop_cnt = w_qempty ? 2'd0 : w_grant;
  assign w_push    = w_ld_acc & ~(w_qempty & (w_grant != 2'd0));

`ifdef WB_PERF_CNT_EN
  logic [$clog2(LQ_DEPTH):0] w_q_new_dead;
`endif

  wb_load_queue #(.LQ_DEPTH(LQ_DEPTH)) u_lq (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_ld_ent),
    .i_pop_cnt    (w_pop_cnt),
    .i_sq_vld     ({p1_valid, p0_valid}),
    .i_sq_rd      ({p1_rd, p0_rd}),
    .o_head0      (w_head0),
    .o_head1      (w_head1),
    .o_count      (lq_count),
    .o_ready      (ld_ready)
`ifdef WB_PERF_CNT_EN
    ,
    .o_new_dead   (w_q_new_dead)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we0 <= 1'b0; r_addr0 <= '0; r_data0 <= '0;
      r_we1 <= 1'b0; r_addr1 <= '0; r_data1 <= '0;
    end else begin
      r_we0 <= w_we0; r_addr0 <= w_addr0; r_data0 <= w_data0;
      r_we1 <= w_we1; r_addr1 <= w_addr1; r_data1 <= w_data1;
    end
  end

  assign rd_we_0   = r_we0;
  assign rd_we_1   = r_we1;
  assign rd_addr_0 = r_addr0;
  assign rd_addr_1 = r_addr1;
  assign rd_data_0 = r_data0;
  assign rd_data_1 = r_data1;

`ifdef WB_PERF_CNT_EN
  logic [15:0] r_perf_stall, r_perf_squash;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall  <= '0;
      r_perf_squash <= '0;
    end else begin
      r_perf_stall  <= sat_add16(r_perf_stall, 16'(ld_valid & ~ld_ready));
      r_perf_squash <= sat_add16(r_perf_squash,
                                 16'(w_q_new_dead) + 16'(w_ld_acc & w_ld_dead));
    end
  end

  assign perf_ld_stall = r_perf_stall;
  assign perf_squash   = r_perf_squash;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: pipe ports, load bypass/queue/drain, squash, reset, perf counters.
module tb_writeback_unit;
  import neocore_pkg::*;

  localparam int LQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p1_valid, ld_valid, ld_ready;
  logic [3:0]  p0_rd, p1_rd, ld_rd, rd_addr_0, rd_addr_1;
  logic [15:0] p0_data, p1_data, ld_data, rd_data_0, rd_data_1;
  logic        rd_we_0, rd_we_1;
  logic [2:0]  lq_count;
`ifdef WB_PERF_CNT_EN
  logic [15:0] perf_ld_stall, perf_squash;
`endif

  logic [15:0] rf [16];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  writeback_unit #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_rd(p0_rd), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_rd(p1_rd), .p1_data(p1_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1),
    .rd_we_0(rd_we_0), .rd_we_1(rd_we_1),
    .lq_count(lq_count)
`ifdef WB_PERF_CNT_EN
    , .perf_ld_stall(perf_ld_stall), .perf_squash(perf_squash)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Register file model: port 1 written last so it wins on an address clash.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_we_0 === 1'b1) rf[rd_addr_0] = rd_data_0;
    if (rd_we_1 === 1'b1) rf[rd_addr_1] = rd_data_1;
  endtask

  task automatic set_pipes(input logic v0, input logic [3:0] r0, input logic [15:0] d0,
                           input logic v1, input logic [3:0] r1, input logic [15:0] d1);
    p0_valid = v0; p0_rd = r0; p0_data = d0;
    p1_valid = v1; p1_rd = r1; p1_data = d1;
  endtask

  task automatic set_ld(input logic v, input logic [3:0] r, input logic [15:0] d);
    ld_valid = v; ld_rd = r; ld_data = d;
  endtask

  task automatic chk_out(input string tag, input logic we0, input logic [3:0] a0,
                         input logic [15:0] d0, input logic we1, input logic [3:0] a1,
                         input logic [15:0] d1);
    chk({tag, ".we0"}, 32'(rd_we_0), 32'(we0));
    if (we0) begin
      chk({tag, ".addr0"}, 32'(rd_addr_0), 32'(a0));
      chk({tag, ".data0"}, 32'(rd_data_0), 32'(d0));
    end
    chk({tag, ".we1"}, 32'(rd_we_1), 32'(we1));
    if (we1) begin
      chk({tag, ".addr1"}, 32'(rd_addr_1), 32'(a1));
      chk({tag, ".data1"}, 32'(rd_data_1), 32'(d1));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    rst = 1'b1;
    set_pipes(0, 0, 0, 0, 0, 0);
    set_ld(0, 0, 0);
    tick(); tick();
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.addr0", 32'(rd_addr_0), 0);
    chk("reset.data1", 32'(rd_data_1), 0);
    chk("reset.count", 32'(lq_count), 0);
    chk("reset.ready", 32'(ld_ready), 0);
    rst = 1'b0;
    tick();
    chk("release.ready", 32'(ld_ready), 1);
    chk("release.count", 32'(lq_count), 0);

    // Both pipes write their own ports
    set_pipes(1, 4'd1, 16'h1234, 1, 4'd2, 16'hABCD);
    tick();
    chk_out("pipes", 1, 4'd1, 16'h1234, 1, 4'd2, 16'hABCD);

    // Load bypass to port 0 when pipes idle
    set_pipes(0, 0, 0, 0, 0, 0);
    set_ld(1, 4'd3, 16'h5678);
    tick();
    chk_out("bypass0", 1, 4'd3, 16'h5678, 0, 0, 0);
    chk("bypass0.count", 32'(lq_count), 0);
    set_ld(0, 0, 0);
    tick();
    chk_out("idle", 0, 0, 0, 0, 0, 0);

    // Pipes busy 5 cycles with load held: fill to 4, then stall
    set_pipes(1, 4'd8, 16'h0808, 1, 4'd9, 16'h0909);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) set_ld(1, 4'(4 + k), 16'((4 + k) * 16'h1001));
      else       set_ld(1, 4'd10, 16'hAAAA);
      tick();
      chk($sformatf("fill%0d.count", k), 32'(lq_count), (k < 4) ? k + 1 : 4);
      chk($sformatf("fill%0d.ready", k), 32'(ld_ready), (k < 3) ? 1 : 0);
    end
    chk_out("fill.out", 1, 4'd8, 16'h0808, 1, 4'd9, 16'h0909);
    set_pipes(0, 0, 0, 0, 0, 0);
    set_ld(0, 0, 0);
    tick();
    chk_out("drain1", 1, 4'd4, 16'h4004, 1, 4'd5, 16'h5005);
    chk("drain1.count", 32'(lq_count), 2);
    tick();
    chk_out("drain2", 1, 4'd6, 16'h6006, 1, 4'd7, 16'h7007);
    chk("drain2.count", 32'(lq_count), 0);
    tick();
    chk_out("drain3", 0, 0, 0, 0, 0, 0);

    // Queued load squashed by later pipe write, popped with no write
    set_pipes(1, 4'd8, 16'h0808, 1, 4'd9, 16'h0909);
    set_ld(1, 4'd5, 16'hBEEF);
    tick();
    chk("sq.count1", 32'(lq_count), 1);
    set_pipes(1, 4'd5, 16'hCAFE, 1, 4'd9, 16'h0909);
    set_ld(0, 0, 0);
    tick();
    chk_out("sq.pipe", 1, 4'd5, 16'hCAFE, 1, 4'd9, 16'h0909);
    chk("sq.count2", 32'(lq_count), 1);
    set_pipes(0, 0, 0, 0, 0, 0);
    tick();
    chk_out("sq.pop", 0, 0, 0, 0, 0, 0);
    chk("sq.count3", 32'(lq_count), 0);
    chk("sq.rf5", 32'(rf[5]), 32'h0000CAFE);

    // Head squashed in the same cycle it is granted port 1
    set_pipes(1, 4'd8, 16'h0808, 1, 4'd9, 16'h0909);
    set_ld(1, 4'd11, 16'h1111);
    tick();
    set_pipes(1, 4'd11, 16'h2222, 0, 0, 0);
    set_ld(0, 0, 0);
    tick();
    chk_out("sqgrant", 1, 4'd11, 16'h2222, 0, 0, 0);
    chk("sqgrant.count", 32'(lq_count), 0);
    set_pipes(0, 0, 0, 0, 0, 0);
    tick();
    chk("sqgrant.rf11", 32'(rf[11]), 32'h00002222);

    // Pop and push in one cycle: queued entry drains, new load enqueues
    set_pipes(1, 4'd8, 16'h0808, 1, 4'd9, 16'h0909);
    set_ld(1, 4'd12, 16'hC0C0);
    tick();
    set_pipes(0, 0, 0, 0, 0, 0);
    set_ld(1, 4'd13, 16'hD0D0);
    tick();
    chk_out("poppush", 1, 4'd12, 16'hC0C0, 0, 0, 0);
    chk("poppush.count", 32'(lq_count), 1);
    set_ld(0, 0, 0);
    tick();
    chk_out("poppush2", 1, 4'd13, 16'hD0D0, 0, 0, 0);
    chk("poppush2.count", 32'(lq_count), 0);

    // Bypass to port 1 while p0 busy
    set_pipes(1, 4'd1, 16'h0111, 0, 0, 0);
    set_ld(1, 4'd3, 16'h0333);
    tick();
    chk_out("bypass1", 1, 4'd1, 16'h0111, 1, 4'd3, 16'h0333);

    // Incoming load squashed by same-cycle p1 write
    set_pipes(0, 0, 0, 1, 4'd3, 16'h3AAA);
    set_ld(1, 4'd3, 16'h3BBB);
    tick();
    chk_out("ldsq", 0, 0, 0, 1, 4'd3, 16'h3AAA);
    chk("ldsq.count", 32'(lq_count), 0);
    chk("ldsq.rf3", 32'(rf[3]), 32'h00003AAA);

    // Reset with three queued entries
    set_pipes(1, 4'd8, 16'h0808, 1, 4'd9, 16'h0909);
    for (int k = 0; k < 3; k++) begin
      set_ld(1, 4'(4 + k), 16'h0F00 + 16'(k));
      tick();
    end
    chk("prerst.count", 32'(lq_count), 3);
    rst = 1'b1;
    set_pipes(0, 0, 0, 0, 0, 0);
    set_ld(0, 0, 0);
    tick();
    chk_out("midrst", 0, 0, 0, 0, 0, 0);
    chk("midrst.addr1", 32'(rd_addr_1), 0);
    chk("midrst.count", 32'(lq_count), 0);
    chk("midrst.ready", 32'(ld_ready), 0);
    rst = 1'b0;
    tick();
    chk_out("postrst1", 0, 0, 0, 0, 0, 0);
    chk("postrst.ready", 32'(ld_ready), 1);
    tick();
    chk_out("postrst2", 0, 0, 0, 0, 0, 0);
    chk("postrst.count", 32'(lq_count), 0);

`ifdef WB_PERF_CNT_EN
    set_pipes(1, 4'd8, 16'h0808, 1, 4'd9, 16'h0909);
    for (int k = 0; k < 4; k++) begin
      set_ld(1, 4'(4 + k), 16'h00A0 + 16'(k));
      tick();
    end
    set_ld(1, 4'd10, 16'hAAAA);
    tick(); tick(); tick();
    chk("perf.stall", 32'(perf_ld_stall), 3);
    chk("perf.squash", 32'(perf_squash), 0);
    set_pipes(0, 0, 0, 0, 0, 0);
    set_ld(0, 0, 0);
    tick(); tick();
    chk("perf.drained", 32'(lq_count), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
